// File: rtl/mii_frame_source.sv
// AXI-stream to MII receive-side nibble source: preamble/SFD, nibble-serialised payload,
// optional Ethernet FCS, underflow abort with drain, and inter-frame gap enforcement.
module mii_frame_source #(
    parameter int ENABLE_FCS       = 1,
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [3:0] mii_rxd,
    output logic       mii_rx_dv,
    output logic       mii_rx_er,
    output logic       start_packet,
    output logic       error_underflow,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_DATA_LO  = 3'd2;
    localparam logic [2:0] ST_DATA_HI  = 3'd3;
    localparam logic [2:0] ST_FCS      = 3'd4;
    localparam logic [2:0] ST_ERR      = 3'd5;
    localparam logic [2:0] ST_DROP     = 3'd6;
    localparam logic [2:0] ST_IFG      = 3'd7;

    localparam int CNT_W = (PREAMBLE_NIBBLES > 7) ? $clog2(PREAMBLE_NIBBLES + 1) : 3;
    localparam int IFG_W = (IFG_NIBBLES > 1) ? $clog2(IFG_NIBBLES + 1) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_NIBBLES);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(7);
    localparam logic [IFG_W-1:0] IFG_MAX  = IFG_W'(IFG_NIBBLES);
    // The IDLE cycle itself is dv-low, so IFG leaves one cycle early to make the gap exact.
    localparam logic [IFG_W-1:0] IFG_EXIT = IFG_W'((IFG_NIBBLES > 1) ? IFG_NIBBLES - 1 : 0);

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IFG_W-1:0] ifg_reg, ifg_next;
    logic [7:0]       byte_reg, byte_next;
    logic             last_reg, last_next;
    logic             user_reg, user_next;
    logic [31:0]      crc_reg, crc_next;
    logic [3:0]       rxd_reg, rxd_next;
    logic             dv_reg, dv_next;
    logic             er_reg, er_next;
    logic [3:0]       fcs_nib [8];

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Transmitted FCS is the complemented CRC, least-significant nibble first.
    for (genvar gi = 0; gi < 8; gi++) begin : g_fcs_nib
        assign fcs_nib[gi] = ~crc_reg[gi*4 +: 4];
    end

    assign s_axis_tready   = (state_reg == ST_PREAMBLE && cnt_reg == PRE_LAST)
                           || (state_reg == ST_DATA_HI && !last_reg)
                           || (state_reg == ST_DROP);
    assign start_packet    = (state_reg == ST_IDLE) && s_axis_tvalid;
    assign error_underflow = s_axis_tready && !s_axis_tvalid && (state_reg != ST_DROP);
    assign busy            = (state_reg != ST_IDLE);
    assign mii_rxd         = rxd_reg;
    assign mii_rx_dv       = dv_reg;
    assign mii_rx_er       = er_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ifg_next   = ifg_reg;
        byte_next  = byte_reg;
        last_next  = last_reg;
        user_next  = user_reg;
        crc_next   = crc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    state_next = ST_PREAMBLE;
                    cnt_next   = '0;
                    crc_next   = 32'hFFFFFFFF;
                    last_next  = 1'b0;
                    user_next  = 1'b0;
                end
            end
            ST_PREAMBLE, ST_DATA_HI: begin
                if (state_reg == ST_PREAMBLE && cnt_reg != PRE_LAST) begin
                    cnt_next = cnt_reg + 1'b1;
                end else if (state_reg == ST_DATA_HI && last_reg) begin
                    if (ENABLE_FCS != 0) begin
                        state_next = ST_FCS;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_IFG;
                        ifg_next   = IFG_W'(1);
                    end
                end else if (s_axis_tvalid) begin
                    state_next = ST_DATA_LO;
                    byte_next  = s_axis_tdata;
                    last_next  = s_axis_tlast;
                    user_next  = s_axis_tuser;
                    crc_next   = crc32_byte(crc_reg, s_axis_tdata);
                end else begin
                    state_next = ST_ERR;
                    cnt_next   = '0;
                end
            end
            ST_DATA_LO: state_next = ST_DATA_HI;
            ST_FCS: begin
                if (cnt_reg == FCS_LAST) begin
                    state_next = ST_IFG;
                    ifg_next   = IFG_W'(1);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_ERR: begin
                if (cnt_reg == '0) begin
                    cnt_next = CNT_W'(1);
                end else begin
                    state_next = last_reg ? ST_IFG : ST_DROP;
                    ifg_next   = IFG_W'(1);
                end
            end
            ST_DROP: begin
                if (ifg_reg != IFG_MAX) ifg_next = ifg_reg + 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_next = ST_IFG;
            end
            ST_IFG: begin
                if (ifg_reg != IFG_MAX) ifg_next = ifg_reg + 1'b1;
                if (ifg_reg >= IFG_EXIT) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered MII pins line up with it.
    always_comb begin
        rxd_next = 4'h0;
        dv_next  = 1'b0;
        er_next  = 1'b0;
        case (state_next)
            ST_PREAMBLE: begin
                dv_next  = 1'b1;
                rxd_next = (cnt_next == PRE_LAST) ? 4'hD : 4'h5;
            end
            ST_DATA_LO: begin
                dv_next  = 1'b1;
                rxd_next = byte_next[3:0];
                er_next  = last_next && user_next;
            end
            ST_DATA_HI: begin
                dv_next  = 1'b1;
                rxd_next = byte_next[7:4];
                er_next  = last_next && user_next;
            end
            ST_FCS: begin
                dv_next  = 1'b1;
                rxd_next = fcs_nib[cnt_next[2:0]];
            end
            ST_ERR: begin
                dv_next = 1'b1;
                er_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ifg_reg   <= '0;
            byte_reg  <= '0;
            last_reg  <= 1'b0;
            user_reg  <= 1'b0;
            crc_reg   <= 32'hFFFFFFFF;
            rxd_reg   <= 4'h0;
            dv_reg    <= 1'b0;
            er_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ifg_reg   <= ifg_next;
            byte_reg  <= byte_next;
            last_reg  <= last_next;
            user_reg  <= user_next;
            crc_reg   <= crc_next;
            rxd_reg   <= rxd_next;
            dv_reg    <= dv_next;
            er_reg    <= er_next;
        end
    end

endmodule

// File: tb/tb_mii_frame_source.sv
// Directed bench for mii_frame_source: FCS frame, back-to-back, underflow, tuser, reset, no-FCS.
`timescale 1ns/1ps
module tb_mii_frame_source;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata;
    logic       tvalid_a, tvalid_b, tlast, tuser;
    logic       tready_a, tready_b;
    logic [3:0] rxd_a, rxd_b;
    logic       dv_a, dv_b, er_a, er_b, sp_a, sp_b, uf_a, uf_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] frame_mem [0:15];
    logic [3:0] nib_q [$];
    logic       er_q [$];
    int         len_q [$];
    int         gap_q [$];
    logic [3:0] nib_b_q [$];
    int         len_b_q [$];
    int         sp_cnt = 0, uf_cnt = 0, er_b_cnt = 0;
    logic       prev_dv_a, seen_a, prev_dv_b;
    int         low_run_a, dv_run_a, dv_run_b;

    always #5 clk = ~clk;

    mii_frame_source dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_a), .s_axis_tready(tready_a),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .mii_rxd(rxd_a), .mii_rx_dv(dv_a), .mii_rx_er(er_a),
        .start_packet(sp_a), .error_underflow(uf_a), .busy(busy_a)
    );

    mii_frame_source #(.ENABLE_FCS(0)) dut_nofcs (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_b), .s_axis_tready(tready_b),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .mii_rxd(rxd_b), .mii_rx_dv(dv_b), .mii_rx_er(er_b),
        .start_packet(sp_b), .error_underflow(uf_b), .busy(busy_b)
    );

    // Passive monitor: records every dv-high nibble, frame lengths and dv-low gaps.
    always @(negedge clk) begin
        if (rst) begin
            prev_dv_a <= 1'b0; seen_a <= 1'b0; low_run_a <= 0; dv_run_a <= 0;
            prev_dv_b <= 1'b0; dv_run_b <= 0;
        end else begin
            sp_cnt <= sp_cnt + int'(sp_a);
            uf_cnt <= uf_cnt + int'(uf_a) + int'(uf_b);
            er_b_cnt <= er_b_cnt + int'(er_b);
            if (dv_a) begin
                nib_q.push_back(rxd_a);
                er_q.push_back(er_a);
                if (!prev_dv_a && seen_a) gap_q.push_back(low_run_a);
                dv_run_a <= dv_run_a + 1;
                low_run_a <= 0;
                seen_a <= 1'b1;
            end else begin
                low_run_a <= low_run_a + 1;
                if (prev_dv_a) begin
                    len_q.push_back(dv_run_a);
                    dv_run_a <= 0;
                end
            end
            prev_dv_a <= dv_a;
            if (dv_b) begin
                nib_b_q.push_back(rxd_b);
                dv_run_b <= dv_run_b + 1;
            end else if (prev_dv_b) begin
                len_b_q.push_back(dv_run_b);
                dv_run_b <= 0;
            end
            prev_dv_b <= dv_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected nibble stream for the "123456789" frame with FCS 0xCBF43926.
    function automatic logic [3:0] exp_nib_123(input int i);
        logic [7:0]  b;
        logic [31:0] fcs;
        fcs = 32'hCBF43926;
        if (i < 15) return 4'h5;
        if (i == 15) return 4'hD;
        if (i < 34) begin
            b = 8'h31 + 8'((i - 16) / 2);
            return ((i % 2) == 0) ? b[3:0] : b[7:4];
        end
        return fcs[(i - 34) * 4 +: 4];
    endfunction

    task automatic drive_frame(input int n, input logic user_last, input int stall_at,
                               input logic use_b, output logic ok);
        int   idx, guard;
        logic hs, stalled, rdy, v;
        idx = 0; guard = 0; hs = 1'b0; stalled = 1'b0; ok = 1'b1;
        forever begin
            if (hs) idx++;
            if (idx >= n) break;
            if (guard >= 1000) begin ok = 1'b0; break; end
            rdy   = use_b ? tready_b : tready_a;
            tdata = frame_mem[idx];
            tlast = (idx == n - 1);
            tuser = user_last && (idx == n - 1);
            v = 1'b1;
            if (idx == stall_at && rdy && !stalled) begin
                v = 1'b0;
                stalled = 1'b1;
            end
            if (use_b) tvalid_b = v; else tvalid_a = v;
            hs = v && rdy;
            guard++;
            step();
        end
        tvalid_a = 1'b0; tvalid_b = 1'b0; tlast = 1'b0; tuser = 1'b0;
        $display("frame: %0d bytes handed over (dut %s) ok=%0d", n, use_b ? "nofcs" : "fcs", ok);
    endtask

    task automatic wait_idle(input logic use_b, output logic ok);
        for (int i = 0; i < 500; i++) begin
            if (!(use_b ? busy_b : busy_a)) break;
            step();
        end
        ok = !(use_b ? busy_b : busy_a);
    endtask

    task automatic test_reset();
        rst = 1'b1; tvalid_a = 1'b0; tvalid_b = 1'b0; tdata = 8'h00; tlast = 1'b0; tuser = 1'b0;
        step(); step();
        checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", dv_a); end
        checks++; if (rxd_a !== 4'h0) begin errors++; $display("FAIL reset_rxd: got %h expected 0", rxd_a); end
        checks++; if (er_a !== 1'b0) begin errors++; $display("FAIL reset_er: got %b expected 0", er_a); end
        checks++; if (tready_a !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", tready_a); end
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", busy_a, busy_b); end
        checks++; if (sp_a !== 1'b0 || sp_b !== 1'b0) begin errors++; $display("FAIL reset_start: got %b%b expected 00", sp_a, sp_b); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_crc_frame();
        int n0, l0, s0, bad, first, got_len, er_ones;
        logic ok, ok2;
        logic [3:0] got_n;
        for (int i = 0; i < 9; i++) frame_mem[i] = 8'h31 + 8'(i);
        n0 = nib_q.size(); l0 = len_q.size(); s0 = sp_cnt;
        drive_frame(9, 1'b0, -1, 1'b0, ok);
        wait_idle(1'b0, ok2);
        checks++; if (!(ok && ok2)) begin errors++; $display("FAIL crc_timeout: got done=%0d expected 1", ok && ok2); end
        got_len = (len_q.size() > l0) ? len_q[l0] : -1;
        checks++; if (got_len != 42) begin errors++; $display("FAIL crc_dv_len: got %0d expected 42", got_len); end
        bad = 0; first = -1; got_n = 4'h0; er_ones = 0;
        for (int i = 0; i < 42; i++) begin
            if (n0 + i >= nib_q.size() || nib_q[n0 + i] !== exp_nib_123(i)) begin
                if (first < 0) begin first = i; got_n = (n0 + i < nib_q.size()) ? nib_q[n0 + i] : 4'hx; end
                bad++;
            end else if (er_q[n0 + i]) er_ones++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL crc_nibbles: %0d wrong, first at %0d got %h expected %h", bad, first, got_n, exp_nib_123(first)); end
        checks++; if (er_ones != 0) begin errors++; $display("FAIL crc_er: got %0d er nibbles expected 0", er_ones); end
        checks++; if (sp_cnt - s0 != 1) begin errors++; $display("FAIL crc_start_packet: got %0d pulses expected 1", sp_cnt - s0); end
    endtask

    task automatic test_back_to_back();
        int n0, l0, g0, s0;
        logic ok1, ok2, ok3;
        frame_mem[0] = 8'hA5;
        n0 = nib_q.size(); l0 = len_q.size(); g0 = gap_q.size(); s0 = sp_cnt;
        drive_frame(1, 1'b0, -1, 1'b0, ok1);
        drive_frame(1, 1'b0, -1, 1'b0, ok2);
        wait_idle(1'b0, ok3);
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL b2b_timeout: got done=%0d expected 1", ok1 && ok2 && ok3); end
        checks++; if (len_q.size() != l0 + 2 || len_q[l0] != 26 || len_q[l0 + 1] != 26) begin
            errors++; $display("FAIL b2b_dv_len: got %0d frames, first len %0d expected 2 frames of 26", len_q.size() - l0, (len_q.size() > l0) ? len_q[l0] : -1);
        end
        checks++; if (nib_q.size() < n0 + 52 || nib_q[n0 + 16] !== 4'h5 || nib_q[n0 + 17] !== 4'hA) begin
            errors++; $display("FAIL b2b_data1: got %h%h expected 5A", (nib_q.size() > n0 + 16) ? nib_q[n0 + 16] : 4'hx, (nib_q.size() > n0 + 17) ? nib_q[n0 + 17] : 4'hx);
        end
        checks++; if (nib_q.size() < n0 + 52 || nib_q[n0 + 42] !== 4'h5 || nib_q[n0 + 43] !== 4'hA) begin
            errors++; $display("FAIL b2b_data2: got %h%h expected 5A", (nib_q.size() > n0 + 42) ? nib_q[n0 + 42] : 4'hx, (nib_q.size() > n0 + 43) ? nib_q[n0 + 43] : 4'hx);
        end
        checks++; if (gap_q.size() < g0 + 2 || gap_q[g0 + 1] != 24) begin
            errors++; $display("FAIL b2b_gap: got %0d expected 24", (gap_q.size() > g0 + 1) ? gap_q[g0 + 1] : -1);
        end
        checks++; if (sp_cnt - s0 != 2) begin errors++; $display("FAIL b2b_start_packet: got %0d expected 2", sp_cnt - s0); end
    endtask

    task automatic test_underflow();
        int n0, l0, g0, u0, er_ones;
        logic ok1, ok2, ok3;
        for (int i = 0; i < 10; i++) frame_mem[i] = 8'h40 + 8'(i);
        n0 = nib_q.size(); l0 = len_q.size(); g0 = gap_q.size(); u0 = uf_cnt;
        drive_frame(10, 1'b0, 3, 1'b0, ok1);
        checks++; if (!ok1) begin errors++; $display("FAIL uf_drain: got drained=%0d expected 1", ok1); end
        frame_mem[0] = 8'hA5;
        drive_frame(1, 1'b0, -1, 1'b0, ok2);
        wait_idle(1'b0, ok3);
        checks++; if (!(ok2 && ok3)) begin errors++; $display("FAIL uf_timeout: got done=%0d expected 1", ok2 && ok3); end
        checks++; if (uf_cnt - u0 != 1) begin errors++; $display("FAIL uf_pulses: got %0d expected 1", uf_cnt - u0); end
        checks++; if (len_q.size() <= l0 || len_q[l0] != 24) begin errors++; $display("FAIL uf_dv_len: got %0d expected 24", (len_q.size() > l0) ? len_q[l0] : -1); end
        er_ones = 0;
        for (int i = 0; i < 24 && n0 + i < er_q.size(); i++) er_ones += int'(er_q[n0 + i]);
        checks++; if (nib_q.size() < n0 + 24 || er_ones != 2 || !er_q[n0 + 22] || !er_q[n0 + 23]
                      || nib_q[n0 + 22] !== 4'h0 || nib_q[n0 + 23] !== 4'h0 || nib_q[n0 + 21] !== 4'h4) begin
            errors++; $display("FAIL uf_err_nibbles: got er count %0d expected 2 at nibbles 22,23 with rxd 0", er_ones);
        end
        checks++; if (gap_q.size() < g0 + 2 || gap_q[g0 + 1] < 24) begin
            errors++; $display("FAIL uf_gap: got %0d expected at least 24", (gap_q.size() > g0 + 1) ? gap_q[g0 + 1] : -1);
        end
    endtask

    task automatic test_tuser();
        int n0, bad, er_ones;
        logic ok1, ok2;
        for (int i = 0; i < 9; i++) frame_mem[i] = 8'h31 + 8'(i);
        n0 = nib_q.size();
        drive_frame(9, 1'b1, -1, 1'b0, ok1);
        wait_idle(1'b0, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL tuser_timeout: got done=%0d expected 1", ok1 && ok2); end
        bad = 0; er_ones = 0;
        for (int i = 0; i < 42; i++) begin
            if (n0 + i >= nib_q.size() || nib_q[n0 + i] !== exp_nib_123(i)) bad++;
            else er_ones += int'(er_q[n0 + i]);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tuser_nibbles_fcs: got %0d wrong nibbles expected 0", bad); end
        checks++; if (er_ones != 2 || nib_q.size() < n0 + 34 || !er_q[n0 + 32] || !er_q[n0 + 33]) begin
            errors++; $display("FAIL tuser_er: got %0d er nibbles expected 2 on last byte", er_ones);
        end
    endtask

    task automatic test_reset_fcs();
        int n0;
        logic ok1, ok2;
        for (int i = 0; i < 9; i++) frame_mem[i] = 8'h31 + 8'(i);
        n0 = nib_q.size();
        drive_frame(9, 1'b0, -1, 1'b0, ok1);
        for (int i = 0; i < 200 && nib_q.size() < n0 + 36; i++) step();
        checks++; if (dv_a !== 1'b1) begin errors++; $display("FAIL rstfcs_in_fcs: got dv %b expected 1", dv_a); end
        rst = 1'b1;
        #1;
        checks++; if (dv_a !== 1'b0 || rxd_a !== 4'h0 || er_a !== 1'b0) begin
            errors++; $display("FAIL rstfcs_outputs: got dv=%b rxd=%h er=%b expected 0 0 0", dv_a, rxd_a, er_a);
        end
        checks++; if (busy_a !== 1'b0 || tready_a !== 1'b0) begin errors++; $display("FAIL rstfcs_busy: got busy=%b tready=%b expected 0 0", busy_a, tready_a); end
        step(); step();
        rst = 1'b0;
        frame_mem[0] = 8'hA5;
        tdata = 8'hA5; tlast = 1'b1; tvalid_a = 1'b1;
        #1;
        checks++; if (sp_a !== 1'b1 || dv_a !== 1'b0) begin errors++; $display("FAIL rstfcs_restart: got start=%b dv=%b expected 1 0", sp_a, dv_a); end
        step();
        checks++; if (dv_a !== 1'b1 || rxd_a !== 4'h5) begin errors++; $display("FAIL rstfcs_preamble: got dv=%b rxd=%h expected 1 5", dv_a, rxd_a); end
        drive_frame(1, 1'b0, -1, 1'b0, ok1);
        wait_idle(1'b0, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL rstfcs_timeout: got done=%0d expected 1", ok1 && ok2); end
    endtask

    task automatic test_no_fcs();
        int n0, l0, u0;
        logic ok1, ok2;
        for (int i = 0; i < 4; i++) frame_mem[i] = 8'h01 + 8'(i);
        n0 = nib_b_q.size(); l0 = len_b_q.size(); u0 = uf_cnt;
        drive_frame(4, 1'b0, -1, 1'b1, ok1);
        wait_idle(1'b1, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL nofcs_timeout: got done=%0d expected 1", ok1 && ok2); end
        checks++; if (len_b_q.size() <= l0 || len_b_q[l0] != 24) begin errors++; $display("FAIL nofcs_dv_len: got %0d expected 24", (len_b_q.size() > l0) ? len_b_q[l0] : -1); end
        checks++; if (nib_b_q.size() != n0 + 24) begin errors++; $display("FAIL nofcs_nibble_count: got %0d expected 24", nib_b_q.size() - n0); end
        checks++; if (nib_b_q.size() < n0 + 24 || nib_b_q[n0 + 16] !== 4'h1 || nib_b_q[n0 + 17] !== 4'h0
                      || nib_b_q[n0 + 22] !== 4'h4 || nib_b_q[n0 + 23] !== 4'h0) begin
            errors++; $display("FAIL nofcs_data: got first/last byte nibbles wrong, expected 1,0 .. 4,0");
        end
        checks++; if (uf_cnt != u0 || er_b_cnt != 0) begin errors++; $display("FAIL nofcs_errors: got uf=%0d er=%0d expected 0 0", uf_cnt - u0, er_b_cnt); end
    endtask

    initial begin
        test_reset();
        test_crc_frame();
        test_back_to_back();
        test_underflow();
        test_tuser();
        test_reset_fcs();
        test_no_fcs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
